// File: rtl/core_pkg.sv
// Shared core constants used by the fetch stage and its testbench.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown when no instruction is held
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  // Fetch unit side
  modport master (
    output imem_addr,
    output out_valid,
    output out_pc,
    output out_instr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready
  );

  // Environment side (memory, decode, branch resolution)
  modport slave (
    input  imem_addr,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next pointers and occupancy; flush wins over any push/pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Storage write; pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) begin
      mem_d[wr_ptr_q] = din;
    end else begin
      mem_d = mem_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Status and head data
  always_comb begin
    dout  = mem_q[rd_ptr_q];
    full  = (count_q == (PW+1)'(DEPTH));
    empty = (count_q == '0);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fills the fetch queue from the
// combinational instruction memory and hands {pc, instr} to decode.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int unsigned EW = XLEN + ILEN;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            push_s;
  logic            pop_s;
  logic            out_valid_s;
  logic            full_s;
  logic            empty_s;
  logic [EW-1:0]   din_s;
  logic [EW-1:0]   dout_s;

  // Handshake: a redirect hides the head so nothing transfers that cycle;
  // a full queue may still accept a fetch when the head leaves simultaneously
  always_comb begin
    out_valid_s = !empty_s && !bus.redirect_valid;
    pop_s       = out_valid_s && bus.out_ready;
    push_s      = !rst && !bus.redirect_valid && (!full_s || pop_s);
    din_s       = {pc_q, bus.imem_instr};
  end

  // Next PC: redirect target (word aligned), sequential advance on a fetch, else hold
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & ~XLEN'(3);
    end else if (push_s) begin
      pc_d = pc_q + XLEN'(4);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.redirect_valid),
    .din   (din_s),
    .dout  (dout_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Outputs: memory address tracks the PC; an empty queue presents pc=0 / NOP
  always_comb begin
    bus.imem_addr = pc_q;
    bus.out_valid = out_valid_s;
    if (!empty_s) begin
      bus.out_pc    = dout_s[EW-1:ILEN];
      bus.out_instr = dout_s[ILEN-1:0];
    end else begin
      bus.out_pc    = '0;
      bus.out_instr = INSTR_NOP;
    end
  end

endmodule
